// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard host transmitter: state encodings,
// PS/2 command bytes and the cycle-count helpers used to size timers.
package kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_BITS,
        ST_ACK,
        ST_DONE
    } tx_state_e;

    typedef enum logic [2:0] {
        LS_IDLE,
        LS_SEND_CMD,
        LS_WAIT_CMD,
        LS_WAIT_ACK,
        LS_SEND_ARG,
        LS_WAIT_ARG
    } led_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // Results are clamped to at least one cycle so a tiny clock never yields a zero-length timer.
    function automatic logic [31:0] us_to_cycles(input int unsigned clk_hz, input int unsigned us);
        logic [63:0] c;
        c = (64'(clk_hz) * 64'(us)) / 64'd1000000;
        return (c == 64'd0) ? 32'd1 : 32'(c);
    endfunction

    function automatic logic [31:0] ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
        logic [63:0] c;
        c = (64'(clk_hz) / 64'd1000) * 64'(ms);
        return (c == 64'd0) ? 32'd1 : 32'(c);
    endfunction

endpackage

// File: rtl/kbd_led_seq.sv
// LED update sequencer (built only with KBD_LED_CMD_EN): sends 0xED, waits for
// the keyboard's 0xFA reply, then sends the LED byte through the transmitter.
module kbd_led_seq
    import kbd_pkg::*;
#(
    parameter int unsigned CLK_HZ = 24000000
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] leds,
    input  logic [7:0] rx_byte,
    input  logic       rx_strobe,
    input  logic       core_idle,
    input  logic       core_done,
    input  logic       core_err,
    output logic       seq_valid,
    output logic [7:0] seq_data,
    output logic       seq_busy,
    output logic       seq_err
);

    localparam logic [31:0] ACK_CYC  = ms_to_cycles(CLK_HZ, 32'd20);
    localparam int          ACK_W    = $clog2(ACK_CYC + 32'd1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYC - 32'd1);

    led_state_e       state_q, state_d;
    logic [2:0]       leds_q, leds_d;
    logic [ACK_W-1:0] wait_q, wait_d;
    logic             err_q, err_d;

    // leds_q holds the value being (or last) sent, so an abandoned sequence is not retried.
    always_comb begin
        state_d   = state_q;
        leds_d    = leds_q;
        wait_d    = wait_q;
        err_d     = 1'b0;
        seq_valid = 1'b0;
        seq_data  = CMD_SET_LED;
        case (state_q)
            LS_IDLE: begin
                if (leds != leds_q && core_idle) begin
                    leds_d  = leds;
                    state_d = LS_SEND_CMD;
                end
            end
            LS_SEND_CMD: begin
                seq_valid = core_idle;
                if (core_idle) state_d = LS_WAIT_CMD;
            end
            LS_WAIT_CMD: begin
                if (core_done) begin
                    state_d = LS_WAIT_ACK;
                    wait_d  = '0;
                end else if (core_err) begin
                    state_d = LS_IDLE;
                end
            end
            LS_WAIT_ACK: begin
                wait_d = wait_q + ACK_W'(1);
                if (rx_strobe) begin
                    if (rx_byte == RSP_ACK) begin
                        state_d = LS_SEND_ARG;
                    end else begin
                        err_d   = 1'b1;
                        state_d = LS_IDLE;
                    end
                end else if (wait_q == ACK_LAST) begin
                    err_d   = 1'b1;
                    state_d = LS_IDLE;
                end
            end
            LS_SEND_ARG: begin
                seq_data  = {5'b0, leds_q};
                seq_valid = core_idle;
                if (core_idle) state_d = LS_WAIT_ARG;
            end
            LS_WAIT_ARG: begin
                if (core_done || core_err) state_d = LS_IDLE;
            end
            default: state_d = LS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LS_IDLE;
            leds_q  <= 3'b000;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign seq_busy = (state_q != LS_IDLE) || (leds != leds_q);
    assign seq_err  = err_q;

endmodule

// File: rtl/kbd_ps2_tx.sv
// PS/2 host-to-keyboard byte transmitter with open-drain line control.
// Optional feature macro: KBD_LED_CMD_EN adds the automatic LED update sequencer.
module kbd_ps2_tx
    import kbd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 24000000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned TIMEOUT_MS = 15
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
`ifdef KBD_LED_CMD_EN
    input  logic [2:0] leds,
    input  logic [7:0] rx_byte,
    input  logic       rx_strobe,
`endif
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err
);

    localparam logic [31:0] INH_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam logic [31:0] TO_CYC  = ms_to_cycles(CLK_HZ, TIMEOUT_MS);
    localparam int          TMR_W   = $clog2(((INH_CYC > TO_CYC) ? INH_CYC : TO_CYC) + 32'd1);
    localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INH_CYC - 32'd1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TO_CYC - 32'd1);

    tx_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       clk_sync_q, data_sync_q;
    logic             clk_prev_q;
    logic             clk_s, data_s, clk_fall;
    logic             core_idle, req_valid;
    logic [7:0]       req_data;

    // Synchronisers idle high to match released open-drain lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign clk_s     = clk_sync_q[1];
    assign data_s    = data_sync_q[1];
    assign clk_fall  = clk_prev_q & ~clk_s;
    assign core_idle = (state_q == ST_IDLE);

`ifdef KBD_LED_CMD_EN
    logic       seq_valid, seq_busy, seq_err;
    logic [7:0] seq_data;

    kbd_led_seq #(.CLK_HZ(CLK_HZ)) u_led_seq (
        .clk       (clk),
        .reset     (reset),
        .leds      (leds),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .core_idle (core_idle),
        .core_done (done_q),
        .core_err  (err_q),
        .seq_valid (seq_valid),
        .seq_data  (seq_data),
        .seq_busy  (seq_busy),
        .seq_err   (seq_err)
    );

    assign req_valid = seq_valid | (tx_valid & ~seq_busy);
    assign req_data  = seq_valid ? seq_data : tx_data;
    assign tx_ready  = core_idle & ~seq_busy;
    assign tx_err    = err_q | seq_err;
`else
    assign req_valid = tx_valid;
    assign req_data  = tx_data;
    assign tx_ready  = core_idle;
    assign tx_err    = err_q;
`endif

    // One shared timer measures the inhibit window, then restarts at REQ as the transfer timeout.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (req_valid) begin
                    shift_d   = req_data;
                    parity_d  = ~^req_data;
                    timer_d   = '0;
                    bit_cnt_d = 4'd0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = (INH_LAST == '0);
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (timer_q == INH_LAST) begin
                    timer_d   = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    state_d   = ST_REQ;
                end else begin
                    timer_d   = timer_q + TMR_W'(1);
                    data_oe_d = ((timer_q + TMR_W'(1)) == INH_LAST);
                end
            end
            ST_REQ: begin
                timer_d = timer_q + TMR_W'(1);
                state_d = ST_BITS;
            end
            ST_BITS: begin
                timer_d = timer_q + TMR_W'(1);
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                timer_d = timer_q + TMR_W'(1);
                if (clk_fall) begin
                    if (!data_s) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                timer_d = timer_q + TMR_W'(1);
                if (clk_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A keyboard stuck after its ack only costs a silent return; no error once done has fired.
        if (state_q != ST_IDLE && state_q != ST_INHIBIT && timer_q == TO_LAST) begin
            state_d   = ST_IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = (state_q != ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;

endmodule

// File: tb/tb_kbd_ps2_tx.sv
// Scoreboard bench for kbd_ps2_tx: a behavioural keyboard clocks frames out of the
// DUT while a monitor checks every tx_done/tx_err against queued expectations.
module tb_kbd_ps2_tx;

    localparam int CLK_HZ     = 1000000;
    localparam int INHIBIT_US = 20;
    localparam int TIMEOUT_MS = 1;
    localparam int INH_CYC    = CLK_HZ * INHIBIT_US / 1000000;
    localparam int TO_CYC     = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int HALF       = 8;

    // kind: 0 = acked frame, 1 = nacked frame, 2 = timeout, 3 = LED reply rejected
    typedef struct {
        logic [7:0] data;
        int         kind;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err;
    logic       dev_clk_pull = 1'b0;
    logic       dev_data_pull = 1'b0;
`ifdef KBD_LED_CMD_EN
    logic [2:0] leds = 3'b000;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_strobe = 1'b0;
`endif

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         evt_cnt = 0;
    int         dev_mode = 0;
    int         abort_edge = 0;
    bit         edge_flag = 1'b0;
    exp_t       exp_q[$];
    logic [10:0] obs_q[$];

    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_pull);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_pull);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    kbd_ps2_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
`ifdef KBD_LED_CMD_EN
        .leds        (leds),
        .rx_byte     (rx_byte),
        .rx_strobe   (rx_strobe),
`endif
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    task automatic check_output(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Frame as the keyboard sees it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    // Behavioural keyboard: answers a host request with 11 clock pulses.
    initial begin
        logic [10:0] frame;
        bit aborted;
        forever begin
            @(negedge clk);
            if (!reset && !ps2_clk_oe && ps2_data_oe) begin
                if (dev_mode == 2) begin
                    while (ps2_data_oe) @(negedge clk);
                end else begin
                    repeat (4) @(negedge clk);
                    frame    = '0;
                    frame[0] = ps2_data_i;
                    aborted  = 1'b0;
                    for (int e = 1; e <= 11 && !aborted; e++) begin
                        if (e == 11 && dev_mode == 0) dev_data_pull = 1'b1;
                        dev_clk_pull = 1'b1;
                        repeat (HALF) @(negedge clk);
                        if (e <= 10) frame[e] = ps2_data_i;
                        if (e == 10) obs_q.push_back(frame);
                        if (e == abort_edge) begin
                            edge_flag    = 1'b1;
                            dev_clk_pull = 1'b0;
                            aborted      = 1'b1;
                            wait (reset);
                        end else begin
                            dev_clk_pull = 1'b0;
                            repeat (HALF) @(negedge clk);
                            dev_data_pull = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: inhibit shape on every request, and one expectation per done/err pulse.
    initial begin
        bit   clk_oe_prev = 1'b0;
        int   inh_len = 0;
        int   inh_ovl = 0;
        int   req_cyc = 0;
        exp_t e;
        logic [10:0] f;
        forever begin
            @(negedge clk);
            if (reset) begin
                clk_oe_prev = 1'b0;
            end else begin
                if (ps2_clk_oe) begin
                    if (!clk_oe_prev) begin
                        inh_len = 0;
                        inh_ovl = 0;
                    end
                    inh_len++;
                    if (ps2_data_oe) inh_ovl++;
                end else if (clk_oe_prev) begin
                    req_cyc = cyc;
                    check_output("inhibit_len", inh_len, INH_CYC);
                    check_output("inhibit_data_overlap", inh_ovl, 1);
                    check_output("req_data_low", int'(ps2_data_oe), 1);
                end
                clk_oe_prev = ps2_clk_oe;

                if (tx_done || tx_err) begin
                    evt_cnt++;
                    check_output("done_err_exclusive", int'(tx_done & tx_err), 0);
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_event", int'({tx_done, tx_err}), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("result_done", int'(tx_done), (e.kind == 0) ? 1 : 0);
                        check_output("result_err", int'(tx_err), (e.kind != 0) ? 1 : 0);
                        if (e.kind <= 1) begin
                            if (obs_q.size() == 0) begin
                                check_output("frame_present", obs_q.size(), 1);
                            end else begin
                                f = obs_q.pop_front();
                                check_output("frame_bits", int'(f), int'(model_frame(e.data)));
                            end
                        end else if (e.kind == 2) begin
                            check_output("timeout_latency", cyc - req_cyc, TO_CYC);
                            check_output("timeout_clk_oe", int'(ps2_clk_oe), 0);
                            check_output("timeout_data_oe", int'(ps2_data_oe), 0);
                            check_output("timeout_ready", int'(tx_ready), 1);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!tx_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) check_output("ready_timeout", int'(tx_ready), 1);
    endtask

    task automatic wait_event(input int budget);
        int start = evt_cnt;
        int k = 0;
        while (evt_cnt == start && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (evt_cnt == start) check_output("event_timeout", evt_cnt - start, 1);
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input int mode, input int kind, input bit poke);
        exp_t e;
        dev_mode = mode;
        if (kind >= 0) begin
            e.data = d;
            e.kind = kind;
            exp_q.push_back(e);
        end
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        if (poke) begin
            repeat (40) @(negedge clk);
            check_output("ready_low_busy", int'(tx_ready), 0);
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
            repeat (3) @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] d;
        bit nack;
        int k;

        repeat (3) @(negedge clk);
        check_output("reset_clk_oe", int'(ps2_clk_oe), 0);
        check_output("reset_data_oe", int'(ps2_data_oe), 0);
        check_output("reset_ready", int'(tx_ready), 1);
        check_output("reset_done", int'(tx_done), 0);
        check_output("reset_err", int'(tx_err), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        apply_stimulus(8'hED, 0, 0, 1'b1);
        wait_event(3000);
        repeat (20) @(negedge clk);
        apply_stimulus(8'h00, 0, 0, 1'b0);
        wait_event(3000);
        repeat (20) @(negedge clk);
        apply_stimulus(8'h01, 0, 0, 1'b0);
        wait_event(3000);
        repeat (20) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            d    = 8'($urandom);
            nack = ($urandom_range(0, 3) == 0);
            apply_stimulus(d, nack ? 1 : 0, nack ? 1 : 0, (i == 2));
            wait_event(3000);
            repeat (20) @(negedge clk);
        end

        apply_stimulus(8'h5A, 1, 1, 1'b0);
        wait_event(3000);
        repeat (20) @(negedge clk);

        apply_stimulus(8'h3C, 2, 2, 1'b0);
        wait_event(3000);
        repeat (20) @(negedge clk);

        abort_edge = 5;
        apply_stimulus(8'($urandom), 0, -1, 1'b0);
        k = 0;
        while (!edge_flag && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!edge_flag) check_output("abort_edge_seen", int'(edge_flag), 1);
        reset = 1'b1;
        #1;
        check_output("abort_clk_oe", int'(ps2_clk_oe), 0);
        check_output("abort_data_oe", int'(ps2_data_oe), 0);
        repeat (3) @(negedge clk);
        check_output("abort_hold_data_oe", int'(ps2_data_oe | ps2_clk_oe), 0);
        reset      = 1'b0;
        abort_edge = 0;
        edge_flag  = 1'b0;
        repeat (5) @(negedge clk);
        apply_stimulus(8'hA7, 0, 0, 1'b0);
        wait_event(3000);
        repeat (20) @(negedge clk);

`ifdef KBD_LED_CMD_EN
        begin
            exp_t e;
            dev_mode = 0;
            e.data = 8'hED; e.kind = 0; exp_q.push_back(e);
            e.data = 8'h04; e.kind = 0; exp_q.push_back(e);
            leds = 3'b100;
            wait_event(3000);
            repeat (5) @(negedge clk);
            check_output("led_ready_low", int'(tx_ready), 0);
            rx_byte = 8'hFA; rx_strobe = 1'b1;
            @(negedge clk);
            rx_strobe = 1'b0;
            wait_event(3000);
            repeat (30) @(negedge clk);

            e.data = 8'hED; e.kind = 0; exp_q.push_back(e);
            e.data = 8'h00; e.kind = 3; exp_q.push_back(e);
            leds = 3'b011;
            wait_event(3000);
            repeat (5) @(negedge clk);
            rx_byte = 8'hFE; rx_strobe = 1'b1;
            @(negedge clk);
            rx_strobe = 1'b0;
            wait_event(3000);
            repeat (300) @(negedge clk);
            check_output("led_no_second_frame", obs_q.size(), 0);
            check_output("led_ready_after", int'(tx_ready), 1);
        end
`endif

        check_output("queues_drained", exp_q.size() + obs_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
